// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper ramp controller.
// Holds FSM encoding, default periods and the half-step coil table.
package stepper_pkg;

    localparam int PERIOD_W = 20;

    localparam logic [PERIOD_W-1:0] CNT_MAX_DEF    = 20'd399_999;
    localparam logic [PERIOD_W-1:0] MIN_PERIOD_DEF = 20'd99_999;
    localparam logic [PERIOD_W-1:0] ACC_STEP_DEF   = 20'd50_000;
    localparam int                  STEPS_W_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEL,
        ST_CRUISE,
        ST_DECEL
    } state_e;

    function automatic logic [3:0] phase_of(input logic [2:0] idx);
        logic [3:0] p;
        case (idx)
            3'd0: p = 4'b0001;
            3'd1: p = 4'b0011;
            3'd2: p = 4'b0010;
            3'd3: p = 4'b0110;
            3'd4: p = 4'b0100;
            3'd5: p = 4'b1100;
            3'd6: p = 4'b1000;
            3'd7: p = 4'b1001;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/stepper_ramp_ctrl_if.sv
// Move-command handshake between the command source and the
// stepper ramp controller.
interface stepper_ramp_ctrl_if #(
    parameter int STEPS_W = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [STEPS_W-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_step_timer.sv
// Step period counter: counts 0..period, tick while at period.
// Clear forces the count back to 0 on the next clock.
module stepper_step_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] period,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == period);

endmodule

// File: rtl/stepper_ramp_ctrl.sv
// Trapezoidal-ramp stepper sequencer: takes move commands, drives the
// half-step coil pattern and emits one pulse per step.
module stepper_ramp_ctrl
    import stepper_pkg::*;
#(
    parameter logic [PERIOD_W-1:0] CNT_MAX    = CNT_MAX_DEF,
    parameter logic [PERIOD_W-1:0] MIN_PERIOD = MIN_PERIOD_DEF,
    parameter logic [PERIOD_W-1:0] ACC_STEP   = ACC_STEP_DEF,
    parameter int                  STEPS_W    = STEPS_W_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    stepper_ramp_ctrl_if.slave cmd,
    input  logic               stop_req,
    output logic [3:0]         phase_out,
    output logic               step_pulse,
    output logic               busy,
    output logic               done,
    output logic [STEPS_W-1:0] steps_done
);

    state_e               state_q, state_d;
    logic                 dir_q, dir_d;
    logic [2:0]           idx_q, idx_d;
    logic [3:0]           phase_q, phase_d;
    logic [STEPS_W-1:0]   rem_q, rem_d;
    logic [STEPS_W-1:0]   ramp_q, ramp_d;
    logic [STEPS_W-1:0]   sdone_q, sdone_d;
    logic [PERIOD_W-1:0]  period_q, period_d;
    logic                 step_q, step_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pend_q, pend_d;

    logic                 tick;
    logic                 tmr_clr;
    logic                 accept;
    logic                 step_ev;
    logic                 stop_act;
    logic [PERIOD_W:0]    per_up;
    logic [PERIOD_W-1:0]  per_inc;
    logic [PERIOD_W-1:0]  per_dec;
    logic [STEPS_W-1:0]   rem_dec;
    logic [STEPS_W-1:0]   rem_step;
    logic [STEPS_W-1:0]   rem_stop;

    stepper_step_timer #(
        .W(PERIOD_W)
    ) u_timer (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .clr   (tmr_clr),
        .period(period_q),
        .tick  (tick)
    );

    // Ready only once the previous command has fully retired.
    assign cmd.cmd_ready = (state_q == ST_IDLE) && !busy_q && !done_q;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign step_ev       = (state_q != ST_IDLE) && tick;
    assign stop_act      = stop_req &&
                           (state_q == ST_ACCEL || state_q == ST_CRUISE);

    // Ramp arithmetic one bit wider so the clamps never wrap.
    always_comb begin
        per_up  = {1'b0, period_q} + {1'b0, ACC_STEP};
        per_inc = per_up[PERIOD_W-1:0];
        if (per_up > {1'b0, CNT_MAX}) begin
            per_inc = CNT_MAX;
        end
        per_dec = period_q - ACC_STEP;
        if ({1'b0, period_q} < ({1'b0, MIN_PERIOD} + {1'b0, ACC_STEP})) begin
            per_dec = MIN_PERIOD;
        end
        rem_dec  = rem_q - STEPS_W'(1);
        rem_step = rem_dec;
        if (stop_act && ramp_q < rem_dec) begin
            rem_step = ramp_q;
        end
        rem_stop = (ramp_q < rem_q) ? ramp_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        ramp_d   = ramp_q;
        sdone_d  = sdone_q;
        period_d = period_q;
        step_d   = 1'b0;
        pend_d   = 1'b0;
        done_d   = pend_q;
        busy_d   = busy_q && !pend_q;
        tmr_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmr_clr = !accept;
                if (accept) begin
                    dir_d    = cmd.cmd_dir;
                    rem_d    = cmd.cmd_steps;
                    period_d = CNT_MAX;
                    ramp_d   = '0;
                    sdone_d  = '0;
                    busy_d   = 1'b1;
                    if (cmd.cmd_steps == '0) begin
                        pend_d = 1'b1;
                    end else begin
                        state_d = ST_ACCEL;
                    end
                end
            end
            default: begin
                if (step_ev) begin
                    tmr_clr = 1'b1;
                    step_d  = 1'b1;
                    idx_d   = dir_q ? idx_q + 3'd1 : idx_q - 3'd1;
                    sdone_d = sdone_q + STEPS_W'(1);
                    rem_d   = rem_step;
                    if (rem_step == '0) begin
                        state_d = ST_IDLE;
                        pend_d  = 1'b1;
                    end else if (rem_step <= ramp_q) begin
                        state_d  = ST_DECEL;
                        period_d = per_inc;
                        ramp_d   = ramp_q - STEPS_W'(1);
                    end else if (period_q > MIN_PERIOD) begin
                        state_d  = ST_ACCEL;
                        period_d = per_dec;
                        ramp_d   = ramp_q + STEPS_W'(1);
                    end else begin
                        state_d = ST_CRUISE;
                    end
                end else if (stop_act) begin
                    rem_d = rem_stop;
                    if (rem_stop == '0) begin
                        state_d = ST_IDLE;
                        pend_d  = 1'b1;
                        tmr_clr = 1'b1;
                    end else begin
                        state_d  = ST_DECEL;
                        period_d = per_inc;
                        ramp_d   = ramp_q - STEPS_W'(1);
                    end
                end
            end
        endcase

        phase_d = phase_of(idx_d);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b1;
            idx_q    <= 3'd0;
            phase_q  <= 4'b0001;
            rem_q    <= '0;
            ramp_q   <= '0;
            sdone_q  <= '0;
            period_q <= CNT_MAX;
            step_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            rem_q    <= rem_d;
            ramp_q   <= ramp_d;
            sdone_q  <= sdone_d;
            period_q <= period_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pend_q   <= pend_d;
        end
    end

    assign phase_out  = phase_q;
    assign step_pulse = step_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign steps_done = sdone_q;

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// Directed bench for stepper_ramp_ctrl with CNT_MAX=9, MIN_PERIOD=3,
// ACC_STEP=3; expected intervals and phases are hand-derived.
module tb_stepper_ramp_ctrl;

    logic        clk;
    logic        rst;
    logic        stop_req;
    logic [3:0]  phase_out;
    logic        step_pulse;
    logic        busy;
    logic        done;
    logic [15:0] steps_done;

    int n_chk;
    int n_fail;

    int iv [0:31];
    int ph [0:31];
    int n_p;
    int last_at;
    int done_n;
    int done_at;
    int busy_first;
    int busy_at_done;
    int ready_after;

    stepper_ramp_ctrl_if #(.STEPS_W(16)) cif ();

    stepper_ramp_ctrl #(
        .CNT_MAX   (20'd9),
        .MIN_PERIOD(20'd3),
        .ACC_STEP  (20'd3),
        .STEPS_W   (16)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .cmd       (cif),
        .stop_req  (stop_req),
        .phase_out (phase_out),
        .step_pulse(step_pulse),
        .busy      (busy),
        .done      (done),
        .steps_done(steps_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic send(input logic dir, input int steps);
        int k;
        k = 0;
        while (!cif.cmd_ready && k < 50) begin
            cyc();
            k++;
        end
        if (!cif.cmd_ready) check("ready_wait", 0, 1);
        cif.cmd_valid = 1'b1;
        cif.cmd_dir   = dir;
        cif.cmd_steps = 16'(steps);
        cyc();
        cif.cmd_valid = 1'b0;
    endtask

    // t=1 is the cycle after acceptance; intervals are measured from t=0.
    task automatic watch(input int stop_t, input int stop_p);
        int t;
        n_p = 0;
        last_at = 0;
        done_n = 0;
        done_at = 0;
        ready_after = -1;
        busy_first = busy;
        busy_at_done = -1;
        t = 1;
        while (t < 300) begin
            if (done_n > 0 && t == done_at + 1) begin
                ready_after = cif.cmd_ready;
                break;
            end
            if (step_pulse) begin
                if (n_p < 32) begin
                    iv[n_p] = t - last_at;
                    ph[n_p] = phase_out;
                end
                n_p++;
                last_at = t;
            end
            if (done) begin
                done_n++;
                done_at = t;
                busy_at_done = busy;
            end
            stop_req = (t == stop_t) || (stop_p != 0 && step_pulse && n_p == stop_p);
            cyc();
            t++;
        end
        stop_req = 1'b0;
        if (ready_after < 0) check("watch_timeout", 0, 1);
    endtask

    task automatic check_ivs(input string tag, input int n, input int e0,
                             input int e1, input int e2, input int e3,
                             input int e4, input int e5, input int e6,
                             input int e7, input int e8, input int e9);
        int exp [0:9];
        exp = '{e0, e1, e2, e3, e4, e5, e6, e7, e8, e9};
        check({tag, "_npulse"}, n_p, n);
        for (int i = 0; i < n && i < 10 && i < n_p; i++) begin
            check($sformatf("%s_iv%0d", tag, i), iv[i], exp[i]);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        stop_req = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_dir = 1'b1;
        cif.cmd_steps = '0;

        do_reset();
        check("rst_phase", phase_out, 4'b0001);
        check("rst_ready", cif.cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_step", step_pulse, 0);
        check("rst_sdone", steps_done, 0);

        // 1: forward 10 steps
        send(1'b1, 10);
        watch(0, 0);
        check("t1_busy_first", busy_first, 1);
        check_ivs("t1", 10, 10, 7, 4, 4, 4, 4, 4, 4, 7, 10);
        check("t1_total", last_at, 58);
        check("t1_phase", phase_out, 4'b0010);
        check("t1_sdone", steps_done, 10);
        check("t1_done_n", done_n, 1);
        check("t1_done_lat", done_at - last_at, 1);
        check("t1_busy_at_done", busy_at_done, 0);
        check("t1_ready_after", ready_after, 1);

        // 2: reverse 3 steps from index 0
        do_reset();
        send(1'b0, 3);
        watch(0, 0);
        check_ivs("t2", 3, 10, 7, 10, 0, 0, 0, 0, 0, 0, 0);
        check("t2_ph0", ph[0], 4'b1001);
        check("t2_ph1", ph[1], 4'b1000);
        check("t2_ph2", ph[2], 4'b1100);
        check("t2_done_n", done_n, 1);

        // 3: zero-step command, back-to-back with the previous done
        send(1'b1, 0);
        watch(0, 0);
        check("t3_busy_first", busy_first, 1);
        check("t3_done_at", done_at, 2);
        check("t3_npulse", n_p, 0);
        check("t3_phase", phase_out, 4'b1100);
        check("t3_sdone", steps_done, 0);
        check("t3_ready_after", ready_after, 1);

        // 4: stop during cruise of a 100-step move
        do_reset();
        send(1'b1, 100);
        watch(0, 4);
        check_ivs("t4", 6, 10, 7, 4, 4, 7, 10, 0, 0, 0, 0);
        check("t4_sdone", steps_done, 6);
        check("t4_done_n", done_n, 1);
        check("t4_done_lat", done_at - last_at, 1);

        // 5: stop on the cycle of the first step event
        send(1'b1, 5);
        watch(9, 0);
        check("t5_npulse", n_p, 1);
        check("t5_iv0", iv[0], 10);
        check("t5_done_at", done_at, 11);
        check("t5_sdone", steps_done, 1);

        // 6: reset mid-move, then a fresh 2-step move
        send(1'b1, 20);
        repeat (25) cyc();
        check("t6_busy_mid", busy, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_phase", phase_out, 4'b0001);
        check("t6_rst_busy", busy, 0);
        cyc();
        rst = 1'b0;
        done_n = 0;
        n_p = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) done_n++;
            if (step_pulse) n_p++;
            cyc();
        end
        check("t6_no_done", done_n, 0);
        check("t6_no_step", n_p, 0);
        send(1'b1, 2);
        watch(0, 0);
        check_ivs("t6", 2, 10, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t6_phase", phase_out, 4'b0010);
        check("t6_sdone", steps_done, 2);
        check("t6_done_n", done_n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
